// File: rtl/race_seq_ctrl_if.sv
// Handshake and control bundle between the race sequencer and its environment.
// The master drives start/abort/race_bit/result_ready; the slave is the sequencer.
interface race_seq_ctrl_if #(
    parameter int ROUNDS = 8
);
    localparam int W = $clog2(ROUNDS + 1);

    logic         start;
    logic         start_ready;
    logic         abort;
    logic         race_bit;
    logic         race_rst_n;
    logic         osc_en;
    logic         busy;
    logic         result_valid;
    logic         result_ready;
    logic [W-1:0] win_count;

    modport master (
        output start, abort, race_bit, result_ready,
        input  start_ready, race_rst_n, osc_en, busy, result_valid, win_count
    );

    modport slave (
        input  start, abort, race_bit, result_ready,
        output start_ready, race_rst_n, osc_en, busy, result_valid, win_count
    );
endinterface

// File: rtl/race_seq_ctrl.sv
// Sequences ROUNDS clear/run/sample races on the race counter and tallies A-wins.
// Optional macro RACE_SEQ_EARLY_EXIT_EN ends each run on the first synchronized A-win.
module race_seq_ctrl #(
    parameter int ROUNDS        = 8,
    parameter int CLR_CYCLES    = 4,
    parameter int WINDOW_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    race_seq_ctrl_if.slave    bus
);
    localparam int W    = $clog2(ROUNDS + 1);
    localparam int TMAX = (CLR_CYCLES > WINDOW_CYCLES) ? CLR_CYCLES : WINDOW_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [W-1:0]  r_round_cnt;
    logic [W-1:0]  r_win_count;
    logic          r_won;
    logic [1:0]    r_sync;
    logic          r_start_ready;
    logic          r_busy;
    logic          r_race_rst_n;
    logic          r_osc_en;
    logic          r_result_valid;

    logic          w_rb_s;
    logic          w_clr_end;
    logic          w_run_end;
    logic          w_last_round;

    // race_bit is asynchronous to clk; only the second flop is ever observed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], bus.race_bit};
        end
    end

    assign w_rb_s       = r_sync[1];
    assign w_clr_end    = (r_timer == TW'(CLR_CYCLES - 1));
    assign w_last_round = (r_round_cnt == W'(ROUNDS - 1));

`ifdef RACE_SEQ_EARLY_EXIT_EN
    assign w_run_end = (r_timer == TW'(WINDOW_CYCLES - 1)) || w_rb_s;
`else
    assign w_run_end = (r_timer == TW'(WINDOW_CYCLES - 1));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_timer        <= '0;
            r_round_cnt    <= '0;
            r_win_count    <= '0;
            r_won          <= 1'b0;
            r_start_ready  <= 1'b1;
            r_busy         <= 1'b0;
            r_race_rst_n   <= 1'b0;
            r_osc_en       <= 1'b0;
            r_result_valid <= 1'b0;
        end else if (r_state != S_IDLE && bus.abort) begin
            // Abort beats a same-cycle result_ready in DONE: the tally is dropped.
            r_state        <= S_IDLE;
            r_timer        <= '0;
            r_start_ready  <= 1'b1;
            r_busy         <= 1'b0;
            r_race_rst_n   <= 1'b0;
            r_osc_en       <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state       <= S_CLEAR;
                        r_timer       <= '0;
                        r_round_cnt   <= '0;
                        r_win_count   <= '0;
                        r_won         <= 1'b0;
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        r_race_rst_n  <= 1'b0;
                        r_osc_en      <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    // Oscillators keep running so the counter sees its clear on comparator edges.
                    r_won <= 1'b0;
                    if (w_clr_end) begin
                        r_state      <= S_RUN;
                        r_timer      <= '0;
                        r_race_rst_n <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_rb_s) begin
                        r_won <= 1'b1;
                    end
                    if (w_run_end) begin
                        r_state  <= S_SAMPLE;
                        r_timer  <= '0;
                        r_osc_en <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    r_win_count  <= r_win_count + W'(r_won);
                    r_round_cnt  <= r_round_cnt + 1'b1;
                    r_race_rst_n <= 1'b0;
                    if (w_last_round) begin
                        r_state        <= S_DONE;
                        r_result_valid <= 1'b1;
                    end else begin
                        r_state  <= S_CLEAR;
                        r_timer  <= '0;
                        r_osc_en <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.result_ready) begin
                        r_state        <= S_IDLE;
                        r_result_valid <= 1'b0;
                        r_busy         <= 1'b0;
                        r_start_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_start_ready  <= 1'b1;
                    r_busy         <= 1'b0;
                    r_race_rst_n   <= 1'b0;
                    r_osc_en       <= 1'b0;
                    r_result_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start_ready  = r_start_ready;
    assign bus.busy         = r_busy;
    assign bus.race_rst_n   = r_race_rst_n;
    assign bus.osc_en       = r_osc_en;
    assign bus.result_valid = r_result_valid;
    assign bus.win_count    = r_win_count;
endmodule

// File: tb/tb_race_seq_ctrl.sv
// Directed-plus-random bench for race_seq_ctrl; a per-round win plan is the reference model.
module tb_race_seq_ctrl;
    localparam int ROUNDS = 8;
    localparam int CLR    = 4;
    localparam int WIN    = 64;
    localparam int R_FULL = CLR + WIN + 1;

    localparam int K_NONE  = 0;
    localparam int K_ABORT = 1;
    localparam int K_RESET = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    race_seq_ctrl_if #(.ROUNDS(ROUNDS)) bus ();

    race_seq_ctrl #(
        .ROUNDS(ROUNDS),
        .CLR_CYCLES(CLR),
        .WINDOW_CYCLES(WIN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".start_ready"}, 32'(bus.start_ready), 1);
        chk({tag, ".busy"}, 32'(bus.busy), 0);
        chk({tag, ".race_rst_n"}, 32'(bus.race_rst_n), 0);
        chk({tag, ".osc_en"}, 32'(bus.osc_en), 0);
        chk({tag, ".result_valid"}, 32'(bus.result_valid), 0);
    endtask

    // pattern: 0 random, 1 all B, 2 all A (rise at run cycle 5), 3 A on even rounds.
    // Returns in the DONE cycle (or just after an abort / reset when stop_kind requests it).
    task automatic measure(input int pattern, input int stop_round, input int stop_kind,
                           output int exp_wins);
        bit raise [ROUNDS];
        int rise  [ROUNDS];
        int runlen;
        bit counted;
        exp_wins = 0;
        for (int r = 0; r < ROUNDS; r++) begin
            case (pattern)
                1: begin raise[r] = 1'b0; rise[r] = 0; end
                2: begin raise[r] = 1'b1; rise[r] = 5; end
                3: begin raise[r] = (r % 2 == 0); rise[r] = 5; end
                default: begin
                    case ($urandom_range(0, 3))
                        0: begin raise[r] = 1'b0; rise[r] = 0; end
                        3: begin raise[r] = 1'b1; rise[r] = WIN - 2 + int'($urandom_range(0, 1)); end
                        default: begin raise[r] = 1'b1; rise[r] = int'($urandom_range(0, WIN - 3)); end
                    endcase
                end
            endcase
            // A rise is only seen if it clears the 2-cycle synchronizer inside the window.
            if (raise[r] && rise[r] <= WIN - 3) exp_wins++;
        end

        chk("pre.start_ready", 32'(bus.start_ready), 1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;

        for (int r = 0; r < ROUNDS; r++) begin
            counted = raise[r] && rise[r] <= WIN - 3;
`ifdef RACE_SEQ_EARLY_EXIT_EN
            runlen = counted ? rise[r] + 3 : WIN;
`else
            runlen = WIN;
`endif
            for (int c = 0; c < CLR; c++) begin
                if (c == 0) begin
                    chk("clear.race_rst_n", 32'(bus.race_rst_n), 0);
                    chk("clear.osc_en", 32'(bus.osc_en), 1);
                    chk("clear.busy", 32'(bus.busy), 1);
                end
                bus.race_bit = 1'b0;
                step();
            end
            for (int o = 0; o < runlen; o++) begin
                if (o == 0) begin
                    chk("run.race_rst_n", 32'(bus.race_rst_n), 1);
                    chk("run.osc_en", 32'(bus.osc_en), 1);
                end
                if (stop_kind == K_ABORT && r == stop_round && o == 3) begin
                    bus.abort = 1'b1;
                    step();
                    bus.abort = 1'b0;
                    bus.race_bit = 1'b0;
                    chk_idle("abort_run");
                    return;
                end
                bus.race_bit = raise[r] && (o >= rise[r]);
                step();
            end
            bus.race_bit = 1'b0;
            chk("sample.osc_en", 32'(bus.osc_en), 0);
            chk("sample.race_rst_n", 32'(bus.race_rst_n), 1);
            chk("sample.result_valid", 32'(bus.result_valid), 0);
            if (stop_kind == K_RESET && r == stop_round) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                chk_idle("reset_mid");
                chk("reset_mid.win_count", 32'(bus.win_count), 0);
                return;
            end
            step();
        end
        chk("done.result_valid", 32'(bus.result_valid), 1);
        chk("done.win_count", 32'(bus.win_count), 32'(exp_wins));
        chk("done.race_rst_n", 32'(bus.race_rst_n), 0);
        chk("done.osc_en", 32'(bus.osc_en), 0);
        chk("done.start_ready", 32'(bus.start_ready), 0);
    endtask

    task automatic accept(input string tag);
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
        chk_idle(tag);
    endtask

    initial begin
        int  exp;
        bit  seen_valid;

        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.race_bit     = 1'b0;
        bus.result_ready = 1'b0;
        rst_n            = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        chk_idle("reset");
        chk("reset.win_count", 32'(bus.win_count), 0);

        measure(1, -1, K_NONE, exp);
        $display("txn all_b: expected wins=%0d", exp);
        accept("all_b.accept");

        measure(2, -1, K_NONE, exp);
        $display("txn all_a: expected wins=%0d", exp);
        accept("all_a.accept");

        measure(3, -1, K_NONE, exp);
        $display("txn alternating: expected wins=%0d", exp);
        accept("alt.accept");

        // Backpressure: result held while ready is low, and a start pulse is ignored.
        measure(0, -1, K_NONE, exp);
        $display("txn backpressure: expected wins=%0d", exp);
        for (int i = 0; i < 20; i++) begin
            bus.start = (i == 7);
            step();
            bus.start = 1'b0;
            chk("bp.result_valid", 32'(bus.result_valid), 1);
            chk("bp.win_count", 32'(bus.win_count), 32'(exp));
            chk("bp.busy", 32'(bus.busy), 1);
        end
        accept("bp.accept");

        // Abort in round 3 RUN, then confirm no result ever appears.
        measure(0, 2, K_ABORT, exp);
        $display("txn abort_run: aborted in round 3");
        seen_valid = 1'b0;
        for (int i = 0; i < ROUNDS * R_FULL + 10; i++) begin
            step();
            if (bus.result_valid) seen_valid = 1'b1;
        end
        chk("abort_run.no_valid", 32'(seen_valid), 0);
        chk("abort_run.busy_after", 32'(bus.busy), 0);

        // Abort together with result_ready in DONE drops the result.
        measure(0, -1, K_NONE, exp);
        bus.abort        = 1'b1;
        bus.result_ready = 1'b1;
        step();
        bus.abort        = 1'b0;
        bus.result_ready = 1'b0;
        $display("txn abort_done: result dropped");
        chk_idle("abort_done");
        step();
        chk("abort_done.stay", 32'(bus.result_valid), 0);

        // Reset during SAMPLE, then a fresh full measurement.
        measure(0, 4, K_RESET, exp);
        $display("txn reset_mid: reset during round 5 sample");
        step();
        measure(0, -1, K_NONE, exp);
        $display("txn after_reset: expected wins=%0d", exp);
        accept("after_reset.accept");

        repeat (2) begin
            measure(0, -1, K_NONE, exp);
            $display("txn random: expected wins=%0d", exp);
            accept("random.accept");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
